// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   UART receive deserializer. Detects the start edge on the oversample tick,
//   samples every bit with a 3-point majority vote at mid-bit, assembles the
//   word LSB- or MSB-first and reports parity and framing errors.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset
//   i_tick       oversample enable, OVS pulses per bit period
//   i_rx         serial line, already synchronized to clk, idle high
//   o_rx_d       last received word
//   o_rx_valid   one-clk pulse when o_rx_d and the error flags update
//   o_parity_err parity mismatch for the word in o_rx_d
//   o_frame_err  a stop bit voted 0 for the word in o_rx_d
//   o_busy       high whenever a frame is being received
module uart_rx_deser #(
    parameter int DATA_BITS  = 8,
    parameter int OVS        = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int MSB_FIRST  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_d,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int TCW = $clog2(OVS);
    localparam int BCW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [TCW-1:0]         r_tc;
    logic [BCW-1:0]         r_bc;
    logic                   r_sc;       // stop-bit index
    logic                   r_s0;       // sample at tc = OVS/2-1
    logic                   r_s1;       // sample at tc = OVS/2
    logic [DATA_BITS-1:0]   r_shreg;
    logic                   r_perr;     // running XOR of data and parity votes
    logic                   r_ferr;

    logic                   w_tc_last;
    logic                   w_vote_tick;
    logic                   w_vote;
    logic                   w_last_bit;
    logic                   w_last_stop;
    logic                   w_deliver;
    logic [BCW-1:0]         w_bit_idx;

    assign w_tc_last   = (r_tc == TCW'(OVS - 1));
    assign w_vote_tick = (r_tc == TCW'(OVS / 2 + 1));
    // The third sample is the live line value on the voting tick itself.
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
    assign w_last_bit  = (r_bc == BCW'(DATA_BITS - 1));
    assign w_last_stop = (r_sc == 1'(STOP_BITS - 1));
    assign w_deliver   = i_tick && (r_state == S_STOP) && w_vote_tick && w_last_stop;
    assign w_bit_idx   = (MSB_FIRST != 0) ? BCW'(DATA_BITS - 1) - r_bc : r_bc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        if (i_tick) begin
            case (r_state)
                S_IDLE:   if (!i_rx) w_next = S_START;
                S_START: begin
                    if (w_vote_tick && w_vote) w_next = S_IDLE;   // false start
                    else if (w_tc_last)        w_next = S_DATA;
                end
                S_DATA: begin
                    if (w_tc_last && w_last_bit)
                        w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (w_tc_last) w_next = S_STOP;
                // The tail of the final stop bit is spent in IDLE so a
                // back-to-back start edge is never missed.
                S_STOP:   if (w_vote_tick && w_last_stop) w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        o_busy = (r_state != S_IDLE);
    end

    // Counters, sampling, word assembly and delivery
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tc         <= '0;
            r_bc         <= '0;
            r_sc         <= 1'b0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_shreg      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            o_rx_d       <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            if (i_tick) begin
                if (r_state == S_IDLE) begin
                    r_tc <= '0;
                    if (!i_rx) begin
                        // The detecting tick is tick 0 of the start bit.
                        r_tc    <= TCW'(1);
                        r_bc    <= '0;
                        r_sc    <= 1'b0;
                        r_shreg <= '0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                    end
                end else begin
                    r_tc <= w_tc_last ? '0 : r_tc + 1'b1;
                    if (r_tc == TCW'(OVS / 2 - 1)) r_s0 <= i_rx;
                    if (r_tc == TCW'(OVS / 2))     r_s1 <= i_rx;

                    if (w_vote_tick) begin
                        case (r_state)
                            S_DATA: begin
                                r_shreg[w_bit_idx] <= w_vote;
                                r_perr             <= r_perr ^ w_vote;
                            end
                            S_PARITY: r_perr <= r_perr ^ w_vote;
                            S_STOP:   if (!w_vote) r_ferr <= 1'b1;
                            default: ;
                        endcase
                    end

                    if (r_state == S_DATA && w_tc_last && !w_last_bit)
                        r_bc <= r_bc + 1'b1;
                    // Only non-final stop bits ever reach the end of their bit.
                    if (r_state == S_STOP && w_tc_last)
                        r_sc <= r_sc + 1'b1;
                    if (w_next == S_IDLE)
                        r_tc <= '0;

                    if (w_deliver) begin
                        o_rx_d       <= r_shreg;
                        o_parity_err <= (PARITY_EN != 0) ? (r_perr ^ (PARITY_ODD != 0)) : 1'b0;
                        o_frame_err  <= r_ferr | ~w_vote;
                        o_rx_valid   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser
//   Directed bench for uart_rx_deser. Four instances cover 8N1, 8E1, 8N2 and
//   7N1 MSB-first; each has its own serial line, all share clock, tick, reset.
module tb_uart_rx_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_tick;
    logic [3:0] rx;

    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic [3:0] vld, pe, fe, bz;

    int tests = 0;
    int fails = 0;
    int tick_num = 0;
    int t_start = 0;
    int vcnt [4];
    int vtick [4];
    int first_valid;

    always #5 clk = ~clk;

    uart_rx_deser u0 (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_rx(rx[0]),
        .o_rx_d(d0), .o_rx_valid(vld[0]), .o_parity_err(pe[0]),
        .o_frame_err(fe[0]), .o_busy(bz[0])
    );

    uart_rx_deser #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_rx(rx[1]),
        .o_rx_d(d1), .o_rx_valid(vld[1]), .o_parity_err(pe[1]),
        .o_frame_err(fe[1]), .o_busy(bz[1])
    );

    uart_rx_deser #(.STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_rx(rx[2]),
        .o_rx_d(d2), .o_rx_valid(vld[2]), .o_parity_err(pe[2]),
        .o_frame_err(fe[2]), .o_busy(bz[2])
    );

    uart_rx_deser #(.DATA_BITS(7), .MSB_FIRST(1)) u3 (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_rx(rx[3]),
        .o_rx_d(d3), .o_rx_valid(vld[3]), .o_parity_err(pe[3]),
        .o_frame_err(fe[3]), .o_busy(bz[3])
    );

    // Valid-pulse monitor: counts pulses and records the tick that produced them.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (vld[k]) begin
                vcnt[k]  = vcnt[k] + 1;
                vtick[k] = tick_num;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One oversample tick, followed by a tick-free clk; returns mid-cycle.
    task automatic do_tick();
        @(negedge clk);
        tick_num++;
        i_tick = 1'b1;
        @(negedge clk);
        i_tick = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // One 16-tick bit; noise_t flips that tick's sample, the final stop bit
    // releases the line after its voting tick.
    task automatic send_bit(input int k, input logic v, input int noise_t, input bit final_stop);
        logic b;
        for (int t = 0; t < 16; t++) begin
            b = v;
            if (t == noise_t) b = ~v;
            if (final_stop && t > 9) b = 1'b1;
            rx[k] = b;
            do_tick();
        end
    endtask

    // bits[i] is the i-th data bit on the wire.
    task automatic send_frame(input int k, input int nbits, input logic [8:0] bits,
                              input bit has_par, input logic par, input int nstop,
                              input logic [1:0] stops, input bit noisy);
        int bi;
        bi = 0;
        t_start = tick_num + 1;
        send_bit(k, 1'b0, noisy ? 7 + (bi % 3) : -1, 1'b0);
        bi++;
        for (int i = 0; i < nbits; i++) begin
            send_bit(k, bits[i], noisy ? 7 + (bi % 3) : -1, 1'b0);
            bi++;
        end
        if (has_par) begin
            send_bit(k, par, noisy ? 7 + (bi % 3) : -1, 1'b0);
            bi++;
        end
        for (int s = 0; s < nstop; s++) begin
            send_bit(k, stops[s], noisy ? 7 + (bi % 3) : -1, s == nstop - 1);
            bi++;
        end
        rx[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            vcnt[k]  = 0;
            vtick[k] = 0;
        end
        rst    = 1'b1;
        i_tick = 1'b0;
        rx     = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check("reset rx_d", {24'd0, d0}, 32'h0);
        check("reset valid", {31'd0, vld[0]}, 32'h0);
        check("reset parity_err", {31'd0, pe[0]}, 32'h0);
        check("reset frame_err", {31'd0, fe[0]}, 32'h0);
        check("reset busy", {28'd0, bz}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle_ticks(5);

        // 8N1 0xA5, ideal timing
        send_frame(0, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b01, 1'b0);
        check("a5 valid count", vcnt[0], 1);
        check("a5 rx_d", {24'd0, d0}, 32'hA5);
        check("a5 parity_err", {31'd0, pe[0]}, 32'h0);
        check("a5 frame_err", {31'd0, fe[0]}, 32'h0);
        check("a5 latency ticks", vtick[0] - t_start, 153);
        check("a5 busy after frame", {31'd0, bz[0]}, 32'h0);
        idle_ticks(4);

        // Start glitch: low for ticks 0-2 only
        rx[0] = 1'b0;
        idle_ticks(3);
        rx[0] = 1'b1;
        idle_ticks(6);
        check("glitch busy tick 8", {31'd0, bz[0]}, 32'h1);
        idle_ticks(1);
        check("glitch busy tick 9", {31'd0, bz[0]}, 32'h0);
        idle_ticks(20);
        check("glitch valid count", vcnt[0], 1);
        check("glitch rx_d held", {24'd0, d0}, 32'hA5);

        // One corrupted mid-sample in every bit
        send_frame(0, 8, 9'h03C, 1'b0, 1'b0, 1, 2'b01, 1'b1);
        check("noise valid count", vcnt[0], 2);
        check("noise rx_d", {24'd0, d0}, 32'h3C);
        check("noise parity_err", {31'd0, pe[0]}, 32'h0);
        check("noise frame_err", {31'd0, fe[0]}, 32'h0);
        idle_ticks(4);

        // 8E1: 0x07 has three ones, so the correct even parity bit is 1
        send_frame(1, 8, 9'h007, 1'b1, 1'b0, 1, 2'b01, 1'b0);
        check("par bad rx_d", {24'd0, d1}, 32'h07);
        check("par bad parity_err", {31'd0, pe[1]}, 32'h1);
        check("par bad frame_err", {31'd0, fe[1]}, 32'h0);
        idle_ticks(3);
        send_frame(1, 8, 9'h007, 1'b1, 1'b1, 1, 2'b01, 1'b0);
        check("par good parity_err", {31'd0, pe[1]}, 32'h0);
        check("par good rx_d", {24'd0, d1}, 32'h07);
        check("par valid count", vcnt[1], 2);
        idle_ticks(4);

        // 8N2 0x55, second stop bit 0
        send_frame(2, 8, 9'h055, 1'b0, 1'b0, 2, 2'b01, 1'b0);
        check("stop rx_d", {24'd0, d2}, 32'h55);
        check("stop frame_err", {31'd0, fe[2]}, 32'h1);
        check("stop parity_err", {31'd0, pe[2]}, 32'h0);
        check("stop valid count", vcnt[2], 1);
        check("stop latency ticks", vtick[2] - t_start, 169);
        idle_ticks(3);

        // Reset in the middle of data bit 3 of the next frame
        send_bit(2, 1'b0, -1, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(2, 1'b1, -1, 1'b0);
        rx[2] = 1'b0;
        idle_ticks(5);
        check("midframe busy", {31'd0, bz[2]}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort rx_d", {24'd0, d2}, 32'h0);
        check("abort valid", {31'd0, vld[2]}, 32'h0);
        check("abort parity_err", {31'd0, pe[2]}, 32'h0);
        check("abort frame_err", {31'd0, fe[2]}, 32'h0);
        check("abort busy", {31'd0, bz[2]}, 32'h0);
        rx[2] = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle_ticks(40);
        check("after abort busy", {31'd0, bz[2]}, 32'h0);
        check("after abort valid count", vcnt[2], 1);

        // 7N1 MSB-first, two frames back to back
        send_frame(3, 7, 9'h041, 1'b0, 1'b0, 1, 2'b01, 1'b0);
        check("msb rx_d frame 1", {25'd0, d3}, 32'h41);
        check("msb valid count 1", vcnt[3], 1);
        first_valid = vtick[3];
        send_frame(3, 7, 9'h016, 1'b0, 1'b0, 1, 2'b01, 1'b0);
        check("msb rx_d frame 2", {25'd0, d3}, 32'h34);
        check("msb valid count 2", vcnt[3], 2);
        check("msb valid spacing", vtick[3] - first_valid, 144);
        check("msb frame_err", {31'd0, fe[3]}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
